// File: rtl/move_seq_streamer.sv
// move_seq_streamer: LFSR-fed move block capture streamed one move per handshake; define MOVE_SEQ_PREFETCH_EN for gapless refill
module move_seq_streamer #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  input  logic [7:0]       gen_seq,
  output logic [12:0]      gen_random,
  output logic [1:0]       gen_restricted,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [1:0]       move,
  output logic [CNT_W-1:0] blk_cnt
);
  logic [7:0] sbuf;
  logic [2:0] cnt;
  logic [15:0] lfsr, lfsr_nx, seed_fix, init_fix;
  logic [1:0] restr;
  logic xfer, cap;
  assign init_fix = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  assign seed_fix = (seed == 16'h0000) ? 16'hACE1 : seed;
  assign lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign move_valid = cnt != 3'd0;
  assign move = sbuf[1:0];
  assign gen_random = lfsr[12:0];
  assign gen_restricted = restr;
  assign xfer = move_valid & move_ready;
`ifdef MOVE_SEQ_PREFETCH_EN
  assign cap = (cnt == 3'd0) | ((cnt == 3'd1) & move_ready);
`else
  assign cap = cnt == 3'd0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= init_fix;
      cnt <= 3'd0;
      sbuf <= 8'd0;
      restr <= 2'd0;
      blk_cnt <= '0;
    end else if (seed_load) begin
      lfsr <= seed_fix;
      cnt <= 3'd0;
      restr <= 2'd0;
    end else if (cap) begin
      sbuf <= gen_seq;
      cnt <= 3'd4;
      restr <= gen_seq[7:6];
      lfsr <= lfsr_nx;
      blk_cnt <= blk_cnt + CNT_W'(1);
    end else if (xfer) begin
      sbuf <= {2'b00, sbuf[7:2]};
      cnt <= cnt - 3'd1;
    end
  end
endmodule

// File: tb/tb_move_seq_streamer.sv
// tb_move_seq_streamer: scoreboard plus directed and table-driven checks for move_seq_streamer
module tb_move_seq_streamer;
`ifdef MOVE_SEQ_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  logic clk = 1'b0, rst, seed_load, move_ready;
  logic [15:0] seed;
  logic [7:0] gen_seq;
  logic [12:0] gen_random, gen_random2;
  logic [1:0] gen_restricted, gen_restricted2, move, move2;
  logic move_valid, move_valid2;
  logic [15:0] blk_cnt;
  logic [1:0] blk2;
  int checks = 0, errors = 0;
  bit mon_on = 1'b0;
  logic [1:0] q[$];
  logic [15:0] mlfsr = 16'hACE1, mblk = 16'd0;
  logic [1:0] mrestr = 2'd0;

  typedef struct {
    logic [7:0] seq;
    logic [1:0] r;
    logic [1:0] m[4];
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  move_seq_streamer dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .gen_seq(gen_seq),
    .gen_random(gen_random), .gen_restricted(gen_restricted), .move_valid(move_valid),
    .move_ready(move_ready), .move(move), .blk_cnt(blk_cnt)
  );

  move_seq_streamer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .gen_seq(gen_seq),
    .gen_random(gen_random2), .gen_restricted(gen_restricted2), .move_valid(move_valid2),
    .move_ready(move_ready), .move(move2), .blk_cnt(blk2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(negedge clk) begin
    int sz;
    bit cap;
    logic [1:0] e;
    if (mon_on) begin
      sz = q.size();
      chk("valid", {31'd0, move_valid}, {31'd0, sz != 0});
      chk("random", {19'd0, gen_random}, {19'd0, mlfsr[12:0]});
      chk("restricted", {30'd0, gen_restricted}, {30'd0, mrestr});
      chk("blk_cnt", {16'd0, blk_cnt}, {16'd0, mblk});
      chk("blk_cnt_w2", {30'd0, blk2}, {30'd0, mblk[1:0]});
      chk("aux_w2", {16'd0, gen_random2, gen_restricted2, move_valid2},
          {16'd0, mlfsr[12:0], mrestr, sz != 0});
      if (move_valid && move_ready) begin
        if (sz == 0) chk("xfer_when_empty", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("move", {30'd0, move}, {30'd0, e});
          chk("move_w2", {30'd0, move2}, {30'd0, e});
        end
      end
      cap = PF ? (sz == 0 || (sz == 1 && move_ready)) : (sz == 0);
      if (rst) begin
        q.delete(); mlfsr = 16'hACE1; mrestr = 2'd0; mblk = 16'd0;
      end else if (seed_load) begin
        q.delete(); mlfsr = (seed == 16'd0) ? 16'hACE1 : seed; mrestr = 2'd0;
      end else if (cap) begin
        for (int k = 0; k < 4; k++) q.push_back(gen_seq[2*k +: 2]);
        mlfsr = step(mlfsr); mrestr = gen_seq[7:6]; mblk = mblk + 16'd1;
      end
    end
  end

  initial begin
    logic [1:0] held;
    tbl[0] = '{seq: 8'hE4, r: 2'd3, m: '{2'd0, 2'd1, 2'd2, 2'd3}};
    tbl[1] = '{seq: 8'h1B, r: 2'd0, m: '{2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[2] = '{seq: 8'h9C, r: 2'd2, m: '{2'd0, 2'd3, 2'd1, 2'd2}};
    tbl[3] = '{seq: 8'h55, r: 2'd1, m: '{2'd1, 2'd1, 2'd1, 2'd1}};
    rst = 1'b1; seed_load = 1'b0; seed = 16'd0; gen_seq = 8'hE4; move_ready = 1'b0;
    tick(1);
    chk("rst_valid", {31'd0, move_valid}, 32'd0);
    chk("rst_restricted", {30'd0, gen_restricted}, 32'd0);
    chk("rst_random", {19'd0, gen_random}, 32'h0CE1);
    chk("rst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
    mon_on = 1'b1;
    rst = 1'b0; move_ready = 1'b1;
    tick(1);
    chk("fill_valid", {31'd0, move_valid}, 32'd1);
    chk("fill_move", {30'd0, move}, 32'd0);
    chk("fill_restricted", {30'd0, gen_restricted}, 32'd3);
    chk("fill_random", {19'd0, gen_random}, 32'h19C3);
    chk("fill_blk_cnt", {16'd0, blk_cnt}, 32'd1);
    tick(1);
    move_ready = 1'b0; held = move;
    chk("pre_stall_move", {30'd0, held}, 32'd1);
    tick(5);
    chk("stall_move", {30'd0, move}, 32'd1);
    chk("stall_valid", {31'd0, move_valid}, 32'd1);
    chk("stall_random", {19'd0, gen_random}, 32'h19C3);
    gen_seq = 8'h1B; move_ready = 1'b1;
    tick(20);
    move_ready = 1'b0;
    tick(2);
    chk("pre_flush_valid", {31'd0, move_valid}, 32'd1);
    seed_load = 1'b1; seed = 16'h0000; move_ready = 1'b1;
    tick(1);
    chk("flush_valid", {31'd0, move_valid}, 32'd0);
    chk("flush_restricted", {30'd0, gen_restricted}, 32'd0);
    chk("flush_random", {19'd0, gen_random}, 32'h0CE1);
    for (int i = 0; i < 4; i++) begin
      seed_load = 1'b1; seed = (i == 3) ? 16'h1234 : 16'h0000;
      gen_seq = tbl[i].seq;
      tick(1);
      seed_load = 1'b0;
      tick(1);
      chk("tbl_restricted", {30'd0, gen_restricted}, {30'd0, tbl[i].r});
      for (int k = 0; k < 4; k++) begin
        chk("tbl_valid", {31'd0, move_valid}, 32'd1);
        chk("tbl_move", {30'd0, move}, {30'd0, tbl[i].m[k]});
        tick(1);
      end
    end
    rst = 1'b1; seed_load = 1'b1; seed = 16'h1234;
    tick(1);
    chk("rst_over_load_random", {19'd0, gen_random}, 32'h0CE1);
    chk("rst_over_load_blk_cnt", {16'd0, blk_cnt}, 32'd0);
    chk("rst_over_load_valid", {31'd0, move_valid}, 32'd0);
    rst = 1'b0; seed_load = 1'b0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
